// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package cpu_mem_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Legal transfer sizes in bytes.
  localparam logic [3:0] XFER_B = 4'd1;
  localparam logic [3:0] XFER_H = 4'd2;
  localparam logic [3:0] XFER_W = 4'd4;
  localparam logic [3:0] XFER_D = 4'd8;

  // A transfer is legal when its size is a supported power of two and the
  // byte address is naturally aligned to that size. Only the three low
  // address bits can affect alignment for sizes up to 8.
  function automatic logic size_legal(input logic [3:0] size, input logic [2:0] addr_lo);
    logic ok;
    case (size)
      XFER_B:  ok = 1'b1;
      XFER_H:  ok = (addr_lo[0] == 1'b0);
      XFER_W:  ok = (addr_lo[1:0] == 2'b00);
      XFER_D:  ok = (addr_lo == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on contention the port
// that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  // Pick a one-hot grant from the current requests and the last winner.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-ported datamem between the CPU
// load/store path (port 0) and the DMA/loader (port 1). Each access runs
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE; illegal accesses skip
// straight from IDLE to DONE with err_o set and never touch the memory.
module dmem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  input  logic [1:0][3:0]        size_i,
  output logic [1:0]             ack_o,
  output logic                   err_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   busy_o,
  output logic [ADDR_W-1:0]      mem_address,
  output logic                   mem_write_en,
  output logic                   mem_read_en,
  output logic [DATA_W-1:0]      mem_write_data,
  output logic [3:0]             mem_xfer_size,
  input  logic [DATA_W-1:0]      mem_read_data
);

  // WAIT counts down from MEM_LAT-1 to zero, so it lasts MEM_LAT cycles.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic              ptr_q, ptr_d;       // last granted port
  logic              gidx_q, gidx_d;     // port owning the current access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        size_q, size_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;

  logic [1:0]        arb_gnt_s;
  logic              arb_valid_s;
  logic              gsel_s;

  rr_arb2 u_rr_arb2 (
    .req   (req_i),
    .last  (ptr_q),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  assign gsel_s = arb_gnt_s[1];

  // Next-state, payload latch, latency counter and response computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          // Latch the winner's payload; the other port is ignored until DONE.
          ptr_d   = gsel_s;
          gidx_d  = gsel_s;
          we_d    = we_i[gsel_s];
          addr_d  = addr_i[gsel_s];
          wdata_d = wdata_i[gsel_s];
          size_d  = size_i[gsel_s];
          if (size_legal(size_i[gsel_s], addr_i[gsel_s][2:0])) begin
            state_d = ISSUE;
          end else begin
            state_d = DONE;
            ack_d   = arb_gnt_s;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_M1;
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          ack_d   = gidx_q ? 2'b10 : 2'b01;
          if (!we_q) begin
            rdata_d = mem_read_data;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Enables are registered and only ever high for the single ISSUE cycle.
    mem_we_d = (state_d == ISSUE) && we_d;
    mem_re_d = (state_d == ISSUE) && !we_d;
    busy_d   = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      gidx_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 4'd0;
      cnt_q    <= 3'd0;
      rdata_q  <= '0;
      ack_q    <= 2'b00;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
    end
  end

  assign ack_o          = ack_q;
  assign err_o          = err_q;
  assign rdata_o        = rdata_q;
  assign busy_o         = busy_q;
  assign mem_address    = addr_q;
  assign mem_write_en   = mem_we_q;
  assign mem_read_en    = mem_re_q;
  assign mem_write_data = wdata_q;
  assign mem_xfer_size  = size_q;

endmodule
